// File: rtl/pipeline_hazard_control.sv
// Pipeline hazard sequencer for the 5-stage RV32 core.
// Scoreboard RAW stalls, memory freeze and redirect flush/squash.
module pipeline_hazard_control #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [TAG_WIDTH-1:0]  dec_rs1,
  input  logic [TAG_WIDTH-1:0]  dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [TAG_WIDTH-1:0]  dec_rd,
  input  logic                  dec_wbv,
  input  logic                  wb_valid,
  input  logic [TAG_WIDTH-1:0]  wb_rd,
  input  logic                  mem_req_valid,
  input  logic                  mem_rsp_valid,
  input  logic                  ex_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] ex_redirect_pc,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_execute,
  output logic                  bubble_de,
  output logic                  flush_fd,
  output logic                  flush_de,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  drop_fetch,
  output logic                  dec_issue,
  output logic [1:0]            ctrl_state,
  output logic                  sb_error
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [TAG_WIDTH-1:0] TAG_ZERO = '0;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];

  logic mem_stall;
  logic hazard;
  logic redirect_fire;
  logic rs1_busy;
  logic rs2_busy;
  logic rd_full;

  logic                inc;
  logic                dec;
  logic                same_tag;
  logic                ovf;
  logic                unf;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Tag 0 slot stays at zero, so reads need no special guard.
  assign rs1_busy = dec_use_rs1
                 && (dec_rs1 != TAG_ZERO)
                 && (cnt[dec_rs1] != '0);
  assign rs2_busy = dec_use_rs2
                 && (dec_rs2 != TAG_ZERO)
                 && (cnt[dec_rs2] != '0);
  assign rd_full  = dec_wbv
                 && (dec_rd != TAG_ZERO)
                 && (cnt[dec_rd] == CNT_MAX);

  assign mem_stall     = mem_req_valid && !mem_rsp_valid;
  assign hazard        = dec_valid
                      && (rs1_busy || rs2_busy || rd_full);
  assign redirect_fire = ex_redirect_valid && !mem_stall;

  assign stall_execute  = mem_stall;
  assign stall_fetch    = mem_stall
                       || (hazard && !redirect_fire);
  assign stall_decode   = stall_fetch;
  assign bubble_de      = hazard && !mem_stall
                       && !redirect_fire;
  assign flush_fd       = redirect_fire;
  assign flush_de       = redirect_fire;
  assign redirect_valid = redirect_fire;
  assign redirect_pc    = ex_redirect_pc;
  assign dec_issue      = dec_valid && !hazard
                       && !mem_stall && !redirect_fire;
  assign drop_fetch     = (state == REDIRECT);
  assign ctrl_state     = state;

  assign inc      = dec_issue && dec_wbv
                 && (dec_rd != TAG_ZERO);
  assign dec      = wb_valid && (wb_rd != TAG_ZERO);
  assign same_tag = inc && dec && (dec_rd == wb_rd);

  // Issue and retire of one tag cancel out.
  assign inc_vec = (inc && !same_tag)
                 ? (NUM_REGS'(1) << dec_rd) : '0;
  assign dec_vec = (dec && !same_tag)
                 ? (NUM_REGS'(1) << wb_rd) : '0;

  assign ovf = inc && !same_tag
            && (cnt[dec_rd] == CNT_MAX);
  assign unf = dec && !same_tag
            && (cnt[wb_rd] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      sb_error <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && cnt[r] != CNT_MAX) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
      if (ovf || unf) begin
        sb_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN, REDIRECT: begin
          if (redirect_fire) begin
            state <= REDIRECT;
          end else if (mem_stall) begin
            state <= MEM_WAIT;
          end else begin
            state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (redirect_fire) begin
            state <= REDIRECT;
          end else if (mem_rsp_valid) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Self-checking bench: directed scenarios plus random traffic
// against a counting model of in-flight register writes.
module tb_pipeline_hazard_control;

  localparam int AW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [TW-1:0] dec_rs1;
  logic [TW-1:0] dec_rs2;
  logic          dec_use_rs1;
  logic          dec_use_rs2;
  logic [TW-1:0] dec_rd;
  logic          dec_wbv;
  logic          wb_valid;
  logic [TW-1:0] wb_rd;
  logic          mem_req_valid;
  logic          mem_rsp_valid;
  logic          ex_redirect_valid;
  logic [AW-1:0] ex_redirect_pc;
  logic          stall_fetch;
  logic          stall_decode;
  logic          stall_execute;
  logic          bubble_de;
  logic          flush_fd;
  logic          flush_de;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          drop_fetch;
  logic          dec_issue;
  logic [1:0]    ctrl_state;
  logic          sb_error;

  pipeline_hazard_control dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wbv(dec_wbv),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .mem_req_valid(mem_req_valid),
    .mem_rsp_valid(mem_rsp_valid),
    .ex_redirect_valid(ex_redirect_valid),
    .ex_redirect_pc(ex_redirect_pc),
    .stall_fetch(stall_fetch),
    .stall_decode(stall_decode),
    .stall_execute(stall_execute),
    .bubble_de(bubble_de),
    .flush_fd(flush_fd), .flush_de(flush_de),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .drop_fetch(drop_fetch),
    .dec_issue(dec_issue),
    .ctrl_state(ctrl_state),
    .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cnt_m [32];
  int st_m  = -1;
  bit err_m = 1'b0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0;
    dec_rd = 0; dec_wbv = 0;
    wb_valid = 0; wb_rd = 0;
    mem_req_valid = 0; mem_rsp_valid = 0;
    ex_redirect_valid = 0; ex_redirect_pc = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Check all outputs mid-cycle, then advance model and clock.
  task automatic step();
    bit ms, hz, rf, iss;
    int ti, td;
    #2;
    ms = mem_req_valid && !mem_rsp_valid;
    hz = dec_valid && (
         (dec_use_rs1 && dec_rs1 != 0 && cnt_m[dec_rs1] > 0)
      || (dec_use_rs2 && dec_rs2 != 0 && cnt_m[dec_rs2] > 0)
      || (dec_wbv && dec_rd != 0 && cnt_m[dec_rd] >= 3));
    rf  = ex_redirect_valid && !ms;
    iss = dec_valid && !hz && !ms && !rf;
    chk("stall_execute", 32'(stall_execute), 32'(ms));
    chk("stall_fetch", 32'(stall_fetch),
        32'(ms || (hz && !rf)));
    chk("stall_decode", 32'(stall_decode),
        32'(ms || (hz && !rf)));
    chk("bubble_de", 32'(bubble_de), 32'(hz && !ms && !rf));
    chk("flush_fd", 32'(flush_fd), 32'(rf));
    chk("flush_de", 32'(flush_de), 32'(rf));
    chk("redirect_valid", 32'(redirect_valid), 32'(rf));
    chk("redirect_pc", redirect_pc, ex_redirect_pc);
    chk("dec_issue", 32'(dec_issue), 32'(iss));
    if (st_m >= 0) begin
      chk("ctrl_state", 32'(ctrl_state), 32'(st_m));
      chk("drop_fetch", 32'(drop_fetch), 32'(st_m == 2));
      chk("sb_error", 32'(sb_error), 32'(err_m));
    end
    if (reset) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      st_m  = 0;
      err_m = 0;
    end else begin
      ti = (iss && dec_wbv && dec_rd != 0) ? int'(dec_rd) : -1;
      td = (wb_valid && wb_rd != 0) ? int'(wb_rd) : -1;
      if (ti != td) begin
        if (ti >= 0) begin
          if (cnt_m[ti] == 3) err_m = 1;
          else cnt_m[ti]++;
        end
        if (td >= 0) begin
          if (cnt_m[td] == 0) err_m = 1;
          else cnt_m[td]--;
        end
      end
      if (st_m >= 0) begin
        if (rf) st_m = 2;
        else if (st_m == 1) st_m = mem_rsp_valid ? 0 : 1;
        else st_m = ms ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy [$];
    foreach (cnt_m[i]) cnt_m[i] = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    step();
    reset = 0;
    settle();
    chk("rst_state", 32'(ctrl_state), 32'd0);
    chk("rst_err", 32'(sb_error), 32'd0);
    step();

    // RAW stall on x5 until the cycle after its writeback
    dec_valid = 1; dec_rd = 5; dec_wbv = 1;
    settle();
    chk("t1_issue", 32'(dec_issue), 32'd1);
    step();
    idle();
    dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1;
    settle();
    chk("t1_stall", 32'(stall_decode), 32'd1);
    chk("t1_bubble", 32'(bubble_de), 32'd1);
    chk("t1_noissue", 32'(dec_issue), 32'd0);
    step();
    step();
    wb_valid = 1; wb_rd = 5;
    settle();
    chk("t1_nobypass", 32'(stall_decode), 32'd1);
    step();
    wb_valid = 0;
    settle();
    chk("t1_release", 32'(dec_issue), 32'd1);
    step();

    // x0 never tracked
    idle();
    dec_valid = 1; dec_wbv = 1; dec_rd = 0;
    dec_use_rs1 = 1; dec_use_rs2 = 1;
    step();
    settle();
    chk("t2_nostall", 32'(stall_decode), 32'd0);
    chk("t2_issue", 32'(dec_issue), 32'd1);
    chk("t2_noerr", 32'(sb_error), 32'd0);
    step();

    // same-tag issue and retire cancel
    idle();
    dec_valid = 1; dec_wbv = 1; dec_rd = 7;
    step();
    wb_valid = 1; wb_rd = 7;
    settle();
    chk("t3_issue", 32'(dec_issue), 32'd1);
    step();
    idle();
    dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 7;
    settle();
    chk("t3_stall", 32'(stall_decode), 32'd1);
    step();
    wb_valid = 1; wb_rd = 7;
    step();
    idle();
    dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 7;
    settle();
    chk("t3_drained", 32'(dec_issue), 32'd1);
    step();

    // plain redirect
    idle();
    ex_redirect_valid = 1; ex_redirect_pc = 32'h100;
    settle();
    chk("t4_flush", 32'(flush_fd), 32'd1);
    chk("t4_pc", redirect_pc, 32'h100);
    step();
    idle();
    settle();
    chk("t4_state", 32'(ctrl_state), 32'd2);
    chk("t4_drop", 32'(drop_fetch), 32'd1);
    step();
    settle();
    chk("t4_run", 32'(ctrl_state), 32'd0);
    step();

    // redirect held behind an outstanding memory access
    mem_req_valid = 1;
    ex_redirect_valid = 1; ex_redirect_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_stall_ex", 32'(stall_execute), 32'd1);
      chk("t5_held", 32'(redirect_valid), 32'd0);
      step();
    end
    mem_rsp_valid = 1;
    settle();
    chk("t5_fire", 32'(redirect_valid), 32'd1);
    step();
    idle();
    settle();
    chk("t5_state", 32'(ctrl_state), 32'd2);
    step();
    step();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      dec_valid   = ($urandom_range(0, 3) != 0);
      dec_rs1     = TW'($urandom_range(0, 7));
      dec_rs2     = TW'($urandom_range(0, 7));
      dec_use_rs1 = $urandom_range(0, 1) == 1;
      dec_use_rs2 = $urandom_range(0, 1) == 1;
      dec_rd      = TW'($urandom_range(0, 7));
      dec_wbv     = ($urandom_range(0, 3) != 0);
      busy.delete();
      for (int t = 1; t < 32; t++)
        if (cnt_m[t] > 0) busy.push_back(t);
      if (busy.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1;
        wb_rd = TW'(busy[$urandom_range(0, busy.size() - 1)]);
      end
      mem_req_valid = ($urandom_range(0, 4) == 0);
      mem_rsp_valid = ($urandom_range(0, 1) == 1);
      ex_redirect_valid = ($urandom_range(0, 9) == 0);
      ex_redirect_pc = $urandom;
      step();
    end

    // underflow is sticky; reset mid-MEM_WAIT clears everything
    idle();
    reset = 1;
    step();
    reset = 0;
    wb_valid = 1; wb_rd = 9;
    step();
    idle();
    settle();
    chk("t6_err", 32'(sb_error), 32'd1);
    dec_valid = 1; dec_wbv = 1; dec_rd = 3;
    step();
    idle();
    mem_req_valid = 1;
    step();
    settle();
    chk("t6_memwait", 32'(ctrl_state), 32'd1);
    chk("t6_err_hold", 32'(sb_error), 32'd1);
    reset = 1;
    step();
    reset = 0;
    idle();
    settle();
    chk("t6_rst_state", 32'(ctrl_state), 32'd0);
    chk("t6_rst_err", 32'(sb_error), 32'd0);
    dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 3;
    settle();
    chk("t6_cnt_clear", 32'(dec_issue), 32'd1);
    step();
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
